fetch_decode_seq: RTL and testbench

//  Instruction fetch/decode sequencer directly upstream of the per-instruction execution

---
 rtl/fetch_decode_seq.sv | 154 +++++++++++++++
 tb/tb_fetch_decode_seq.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_seq.sv
// Instruction fetch/decode sequencer: fetch opcode into IR, decode, start one execution unit, wait for done.
// Optional macro ILLEGAL_TRAP_EN: illegal opcodes start the interrupt entry unit instead of acting as a NOP.
module fetch_decode_seq #(
    parameter int WAIT_MAX  = 255,
    parameter int NUM_UNITS = 5
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [7:0]           mem_data,
    input  logic                 exec_done,
    input  logic                 int_req,
    input  logic                 int_en,
    output logic                 enpca,
    output logic                 mr_n,
    output logic                 lir,
    output logic                 incpc,
    output logic [7:0]           ir,
    output logic [NUM_UNITS-1:0] exec_start,
    output logic                 int_ack,
    output logic                 halted,
    output logic                 timeout
);
    localparam int         INT_UNIT = 4;
    localparam logic [7:0] WMAX_M1  = 8'(WAIT_MAX - 1);

    typedef enum logic [3:0] {
        S_F0, S_F1, S_F2, S_F3, S_DEC, S_DSP, S_WAIT, S_BND, S_IACK, S_HALT
    } state_t;

    state_t               state_q;
    logic [7:0]           ir_q;
    logic [7:0]           cnt_q;
    logic                 enpca_q, mr_n_q, lir_q, incpc_q, int_ack_q, halted_q, timeout_q;
    logic [NUM_UNITS-1:0] start_q;
    logic [NUM_UNITS-1:0] dec_start_d;
    logic                 dec_halt_d;
    logic                 irq_d;

    assign irq_d = int_req && int_en;

    // Decode is purely a function of the latched opcode; only consumed in DEC.
    always_comb begin
        dec_start_d = '0;
        dec_halt_d  = 1'b0;
        if (ir_q == 8'hFF) begin
            dec_halt_d = 1'b1;
        end else begin
            case (ir_q[7:4])
                4'h0: ;
                4'h1: dec_start_d[0] = 1'b1;
                4'h2: dec_start_d[1] = 1'b1;
                4'h3: dec_start_d[2] = 1'b1;
                4'h4: dec_start_d[3] = 1'b1;
`ifdef ILLEGAL_TRAP_EN
                default: dec_start_d[INT_UNIT] = 1'b1;
`else
                default: ;
`endif
            endcase
        end
    end

    // Outputs are registered alongside the state they belong to.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_F0;
            ir_q      <= 8'h00;
            cnt_q     <= 8'h00;
            enpca_q   <= 1'b0;
            mr_n_q    <= 1'b1;
            lir_q     <= 1'b0;
            incpc_q   <= 1'b0;
            start_q   <= '0;
            int_ack_q <= 1'b0;
            halted_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            enpca_q   <= 1'b0;
            mr_n_q    <= 1'b1;
            lir_q     <= 1'b0;
            incpc_q   <= 1'b0;
            start_q   <= '0;
            int_ack_q <= 1'b0;
            halted_q  <= 1'b0;
            case (state_q)
                S_F0: begin
                    state_q <= S_F1;
                    enpca_q <= 1'b1;
                    mr_n_q  <= 1'b0;
                end
                S_F1: begin
                    state_q <= S_F2;
                    enpca_q <= 1'b1;
                    mr_n_q  <= 1'b0;
                    lir_q   <= 1'b1;
                end
                S_F2: begin
                    state_q <= S_F3;
                    ir_q    <= mem_data;
                    incpc_q <= 1'b1;
                end
                S_F3: state_q <= S_DEC;
                S_DEC: begin
                    if (dec_halt_d) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else if (|dec_start_d) begin
                        state_q <= S_DSP;
                        start_q <= dec_start_d;
                    end else begin
                        state_q <= S_BND;
                    end
                end
                S_DSP, S_IACK: begin
                    state_q <= S_WAIT;
                    cnt_q   <= 8'h00;
                end
                S_WAIT: begin
                    if (exec_done) begin
                        state_q <= S_BND;
                    end else if (cnt_q == WMAX_M1) begin
                        state_q   <= S_BND;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_BND, S_HALT: begin
                    if (irq_d) begin
                        state_q            <= S_IACK;
                        int_ack_q          <= 1'b1;
                        start_q[INT_UNIT]  <= 1'b1;
                    end else if (state_q == S_HALT) begin
                        halted_q <= 1'b1;
                    end else begin
                        state_q <= S_F0;
                        enpca_q <= 1'b1;
                    end
                end
                default: state_q <= S_F0;
            endcase
        end
    end

    assign enpca      = enpca_q;
    assign mr_n       = mr_n_q;
    assign lir        = lir_q;
    assign incpc      = incpc_q;
    assign ir         = ir_q;
    assign exec_start = start_q;
    assign int_ack    = int_ack_q;
    assign halted     = halted_q;
    assign timeout    = timeout_q;
endmodule

// File: tb/tb_fetch_decode_seq.sv
// Directed bench for fetch_decode_seq (WAIT_MAX=4); cycle N = state after the Nth posedge past reset release.
module tb_fetch_decode_seq;
    logic       clock, reset_n, exec_done, int_req, int_en;
    logic [7:0] mem_data, ir;
    logic       enpca, mr_n, lir, incpc, int_ack, halted, timeout;
    logic [4:0] exec_start;
    int checks = 0;
    int failures = 0;

    fetch_decode_seq #(.WAIT_MAX(4), .NUM_UNITS(5)) dut (
        .clock(clock), .reset_n(reset_n), .mem_data(mem_data), .exec_done(exec_done),
        .int_req(int_req), .int_en(int_en), .enpca(enpca), .mr_n(mr_n), .lir(lir),
        .incpc(incpc), .ir(ir), .exec_start(exec_start), .int_ack(int_ack),
        .halted(halted), .timeout(timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    task automatic do_reset(input logic [7:0] op);
        reset_n = 1'b0; exec_done = 1'b0; int_req = 1'b0; int_en = 1'b0; mem_data = op;
        @(negedge clock); @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; exec_done = 1'b0; int_req = 1'b0; int_en = 1'b0; mem_data = 8'h55;
        @(negedge clock); @(negedge clock);
        checks++; if ({enpca, mr_n, lir, incpc} !== 4'b0100) begin failures++; $display("FAIL reset_ctrl got %b exp 0100", {enpca, mr_n, lir, incpc}); end
        checks++; if (ir !== 8'h00) begin failures++; $display("FAIL reset_ir got %h exp 00", ir); end
        checks++; if ({exec_start, int_ack, halted, timeout} !== 8'h00) begin failures++; $display("FAIL reset_misc got %b exp 0", {exec_start, int_ack, halted, timeout}); end
        reset_n = 1'b1;
    endtask

    task automatic test_fetch;
        do_reset(8'h31);
        tick(1);
        checks++; if ({enpca, mr_n, lir} !== 3'b100) begin failures++; $display("FAIL fetch_f1 got %b exp 100", {enpca, mr_n, lir}); end
        tick(1);
        checks++; if ({enpca, mr_n, lir} !== 3'b101) begin failures++; $display("FAIL fetch_f2 got %b exp 101", {enpca, mr_n, lir}); end
        tick(1);
        checks++; if (ir !== 8'h31 || incpc !== 1'b1) begin failures++; $display("FAIL fetch_ir got ir=%h incpc=%b exp ir=31 incpc=1", ir, incpc); end
        tick(2);
        checks++; if (exec_start !== 5'b00100) begin failures++; $display("FAIL fetch_start got %b exp 00100", exec_start); end
    endtask

    task automatic test_done;
        do_reset(8'h31);
        tick(5);
        exec_done = 1'b1;
        tick(1);
        exec_done = 1'b0;
        checks++; if (enpca !== 1'b0 || exec_start !== 5'b0) begin failures++; $display("FAIL done_in_dsp got enpca=%b start=%b exp 0 0", enpca, exec_start); end
        tick(1);
        checks++; if (enpca !== 1'b0) begin failures++; $display("FAIL done_still_wait got enpca=%b exp 0", enpca); end
        exec_done = 1'b1;
        tick(1);
        exec_done = 1'b0;
        checks++; if (enpca !== 1'b0) begin failures++; $display("FAIL done_bnd got enpca=%b exp 0", enpca); end
        tick(1);
        checks++; if ({enpca, mr_n} !== 2'b11) begin failures++; $display("FAIL done_f0 got %b exp 11", {enpca, mr_n}); end
    endtask

    task automatic test_nop_stream;
        do_reset(8'h00);
        for (int c = 1; c <= 24; c++) begin
            tick(1);
            checks++; if (incpc !== ((c % 6) == 3)) begin failures++; $display("FAIL nop_incpc cyc=%0d got %b exp %b", c, incpc, (c % 6) == 3); end
            checks++; if (exec_start !== 5'b0) begin failures++; $display("FAIL nop_start cyc=%0d got %b exp 0", c, exec_start); end
        end
    endtask

    task automatic test_halt;
        do_reset(8'hFF);
        tick(5);
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_enter got %b exp 1", halted); end
        int_req = 1'b1;
        tick(2);
        checks++; if (halted !== 1'b1 || int_ack !== 1'b0) begin failures++; $display("FAIL halt_masked got halted=%b ack=%b exp 1 0", halted, int_ack); end
        int_en = 1'b1;
        tick(1);
        checks++; if ({int_ack, exec_start, halted} !== 7'b1100000) begin failures++; $display("FAIL halt_wake got %b exp 1100000", {int_ack, exec_start, halted}); end
        int_req = 1'b0; mem_data = 8'h00;
        tick(1);
        checks++; if (int_ack !== 1'b0 || exec_start !== 5'b0) begin failures++; $display("FAIL halt_ack_pulse got ack=%b start=%b exp 0 0", int_ack, exec_start); end
        exec_done = 1'b1;
        tick(1);
        exec_done = 1'b0;
        tick(1);
        checks++; if ({enpca, mr_n, halted} !== 3'b110) begin failures++; $display("FAIL halt_resume got %b exp 110", {enpca, mr_n, halted}); end
    endtask

    task automatic test_timeout;
        do_reset(8'h41);
        tick(5);
        checks++; if (exec_start !== 5'b01000) begin failures++; $display("FAIL to_start got %b exp 01000", exec_start); end
        tick(4);
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL to_early got %b exp 0", timeout); end
        tick(1);
        checks++; if (timeout !== 1'b1 || enpca !== 1'b0) begin failures++; $display("FAIL to_set got to=%b enpca=%b exp 1 0", timeout, enpca); end
        tick(1);
        checks++; if ({enpca, mr_n} !== 2'b11) begin failures++; $display("FAIL to_resume got %b exp 11", {enpca, mr_n}); end
        tick(6);
        int_req = 1'b1; int_en = 1'b1;
        tick(1);
        checks++; if (int_ack !== 1'b0) begin failures++; $display("FAIL to_irq_in_wait got %b exp 0", int_ack); end
        tick(4);
        checks++; if ({int_ack, exec_start, timeout} !== 7'b1100001) begin failures++; $display("FAIL to_iack got %b exp 1100001", {int_ack, exec_start, timeout}); end
        int_req = 1'b0; int_en = 1'b0;
    endtask

    task automatic test_reset_midflight;
        do_reset(8'h31);
        tick(1);
        reset_n = 1'b0; #1;
        checks++; if ({enpca, mr_n} !== 2'b01) begin failures++; $display("FAIL rst_f1 got %b exp 01", {enpca, mr_n}); end
        @(negedge clock); reset_n = 1'b1;
        tick(5);
        reset_n = 1'b0; #1;
        checks++; if (exec_start !== 5'b0 || mr_n !== 1'b1) begin failures++; $display("FAIL rst_dsp got start=%b mr_n=%b exp 0 1", exec_start, mr_n); end
        @(negedge clock); reset_n = 1'b1;
        tick(6);
        reset_n = 1'b0; #1;
        checks++; if (ir !== 8'h00 || timeout !== 1'b0) begin failures++; $display("FAIL rst_wait got ir=%h to=%b exp 00 0", ir, timeout); end
        @(negedge clock); reset_n = 1'b1;
        tick(1);
        checks++; if ({enpca, mr_n} !== 2'b10) begin failures++; $display("FAIL rst_restart got %b exp 10", {enpca, mr_n}); end
    endtask

    task automatic test_illegal;
        do_reset(8'h9A);
        tick(5);
`ifdef ILLEGAL_TRAP_EN
        checks++; if ({exec_start, int_ack} !== 6'b100000) begin failures++; $display("FAIL ill_trap got %b exp 100000", {exec_start, int_ack}); end
`else
        checks++; if ({exec_start, int_ack, enpca} !== 7'b0) begin failures++; $display("FAIL ill_nop got %b exp 0", {exec_start, int_ack, enpca}); end
        tick(1);
        checks++; if ({enpca, mr_n} !== 2'b11) begin failures++; $display("FAIL ill_f0 got %b exp 11", {enpca, mr_n}); end
`endif
    endtask

    initial begin
        test_reset;
        test_fetch;
        test_done;
        test_nop_stream;
        test_halt;
        test_timeout;
        test_reset_midflight;
        test_illegal;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
